dyn_pattern_det_param: RTL and testbench
========================================

Name: dyn_pattern_det_param

Overview:
Runtime-programmable serial pattern detector: the successor to the fixed 3-bit detector.
- Pattern length is configurable at runtime, 1..MAX_LEN bits.
- Overlapping or non-overlapping detection is selected at runtime.
- Produces a registered match pulse and a saturating match counter.
- Sits on a valid-qualified 1-bit serial input stream behind the bit-deserialiser front end.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, 4, width of the length field; must satisfy 2^LEN_W > MAX_LEN.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cfg_we  input  1  load configuration this cycle.
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
valid  input  1  in is sampled when high.
in  input  1  serial data bit.
armed  output  1  a legal configuration is loaded.
match  output  1  one-cycle pulse, the cycle after the completing sample.
match_cnt  output  CNT_W  matches since reset or last config; saturates.
cfg_err  output  1  one-cycle pulse when a cfg_we write is rejected.

Behaviour:
- Reset: rst takes priority over everything.
  - Reset clears armed, match, cfg_err, match_cnt, history register, fill counter, and the stored pattern, length and mode.
  - Reset value of all outputs is 0.
- State machine (encoding in the package):
  - UNCFG: initial state after reset; valid samples are ignored.
  - FILL: fewer than len bits collected since arming or the last match.
  - HUNT: at least len bits collected; a comparison is made on every valid sample.
- armed = 1 in FILL and HUNT.
- Config write (cfg_we = 1):
  - If 1 <= cfg_len <= MAX_LEN: store pattern, length and mode; clear history, fill and match_cnt; go to FILL.
  - Otherwise: pulse cfg_err the next cycle; keep the state and stored config unchanged.
  - cfg_we together with valid: the config wins and the sample is dropped.
  - A write is accepted in any state.
- Sample (valid = 1, cfg_we = 0, armed):
  - history <= {history[MAX_LEN-2:0], in}.
  - fill increments and saturates at len.
- Match condition: the new history[len-1:0] equals pattern[len-1:0] and the new fill >= len.
  - The comparison uses the post-shift value; bits above len-1 are don't-care.
  - On a match, match = 1 on the following cycle, for exactly one cycle.
- After a match:
  - Overlap = 1: stay in HUNT with history intact, so the next valid sample can match again.
  - Overlap = 0: clear fill and go to FILL, so the next match needs len fresh bits.
- valid = 0: history, fill and state hold; no match pulse.
- len = 1 is legal: every valid sample equal to pattern[0] matches.
- match_cnt increments on each match and holds at 2^CNT_W-1.
- Latency: the completing sample is clocked on edge N; match is high from edge N to edge N+1.

Decomposition:
- Package dyn_pattern_pkg holds:
  - state enum UNCFG/FILL/HUNT as localparams;
  - the length-legality check function.
- Sub-module dyn_pattern_satcnt: CNT_W-wide saturating counter with synchronous clear and increment enable. It is used for match_cnt.
- The top level holds config registers, history, fill, FSM and the compare.

Test Plan:
- Reset, then valid bursts with no cfg_we -> armed = 0, match never asserted, match_cnt = 0.
- cfg_len = 3, pattern 3'b010, overlap = 0, input 0,1,0,1,0 -> one match pulse, after the 3rd bit only; match_cnt = 1.
- Same stream with overlap = 1 -> match pulses after bits 3 and 5; match_cnt = 2.
- cfg_len = 8, pattern 8'hA5, overlap = 0; stream 0xA5 MSB-first with valid deasserted randomly between bits -> single match the cycle after the last bit; idle cycles do not break the match.
- cfg_len = 0, then cfg_len = 9 while armed with len 3 -> cfg_err pulses twice; old config keeps detecting 010.
- CNT_W = 2, overlap = 1, len = 1, pattern 1, then 6 consecutive 1s -> 6 match pulses; match_cnt stops at 3. cfg_we mid-stream -> match_cnt = 0 and history cleared. rst mid-pattern -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dyn_pattern_pkg.sv
// rtl/dyn_pattern_pkg.sv - shared state encoding and config checks for the pattern detector
package dyn_pattern_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_FILL  = 2'd1,
    ST_HUNT  = 2'd2
  } state_t;

  function automatic logic len_ok(input logic [31:0] len, input logic [31:0] max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/dyn_pattern_satcnt.sv
// rtl/dyn_pattern_satcnt.sv - saturating counter with synchronous clear and increment enable
module dyn_pattern_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dyn_pattern_det_param.sv
// rtl/dyn_pattern_det_param.sv - runtime-programmable serial pattern detector
module dyn_pattern_det_param
  import dyn_pattern_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               valid,
  input  logic               in,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic               w_cfg_load;
  logic               w_sample;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_full;
  logic               w_hit;

  assign w_cfg_ok   = len_ok(32'(cfg_len), 32'(MAX_LEN));
  assign w_cfg_load = cfg_we && w_cfg_ok;
  // A config write always wins over a sample arriving in the same cycle.
  assign w_sample   = valid && !cfg_we && (r_state != ST_UNCFG);
  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_inc = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
  assign w_mask     = ~({MAX_LEN{1'b1}} << r_len);
  assign w_full     = (w_fill_inc >= r_len);
  assign w_hit      = w_sample && w_full && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNCFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_we) begin
      if (w_cfg_ok) begin
        w_state_nxt = ST_FILL;
      end
    end else if (w_sample) begin
      if (w_hit && !r_overlap) begin
        w_state_nxt = ST_FILL;
      end else if (w_full) begin
        w_state_nxt = ST_HUNT;
      end else begin
        w_state_nxt = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (w_sample) begin
        r_hist <= w_hist_nxt;
        // Non-overlapping mode demands a full fresh window after each match.
        r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
      end
    end
  end

  dyn_pattern_satcnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cfg_load),
    .i_inc (w_hit),
    .o_cnt (match_cnt)
  );

  assign armed   = (r_state != ST_UNCFG);
  assign match   = r_match;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_dyn_pattern_det_param.sv
// tb/tb_dyn_pattern_det_param.sv - directed self-checking bench for dyn_pattern_det_param
module tb_dyn_pattern_det_param;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       valid;
  logic       in_bit;
  logic       armed;
  logic       match;
  logic [1:0] match_cnt;
  logic       cfg_err;

  int checks;
  int failures;

  dyn_pattern_det_param #(
    .MAX_LEN (8),
    .LEN_W   (4),
    .CNT_W   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .valid       (valid),
    .in          (in_bit),
    .armed       (armed),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cfg_we = 1'b0;
    valid  = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    tick();
  endtask

  task automatic bit_in(input logic b, input logic exp_m, input string tag);
    valid  = 1'b1;
    in_bit = b;
    tick();
    check(tag, 32'(match), 32'(exp_m));
  endtask

  task automatic idle(input string tag);
    tick();
    check(tag, 32'(match), 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    valid       = 1'b0;
    in_bit      = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    // Unconfigured: samples ignored
    bit_in(1'b0, 1'b0, "uncfg_m0");
    bit_in(1'b1, 1'b0, "uncfg_m1");
    bit_in(1'b0, 1'b0, "uncfg_m2");
    bit_in(1'b1, 1'b0, "uncfg_m3");
    check("uncfg_armed", 32'(armed), 32'd0);
    check("uncfg_cnt", 32'(match_cnt), 32'd0);

    // len 3, 010, non-overlap
    cfg(8'h02, 4'd3, 1'b0);
    check("cfg3_armed", 32'(armed), 32'd1);
    check("cfg3_err", 32'(cfg_err), 32'd0);
    bit_in(1'b0, 1'b0, "nov_b1");
    bit_in(1'b1, 1'b0, "nov_b2");
    bit_in(1'b0, 1'b1, "nov_b3");
    bit_in(1'b1, 1'b0, "nov_b4");
    bit_in(1'b0, 1'b0, "nov_b5");
    check("nov_cnt", 32'(match_cnt), 32'd1);

    // Same stream, overlap
    cfg(8'h02, 4'd3, 1'b1);
    check("ov_cnt_clr", 32'(match_cnt), 32'd0);
    bit_in(1'b0, 1'b0, "ov_b1");
    bit_in(1'b1, 1'b0, "ov_b2");
    bit_in(1'b0, 1'b1, "ov_b3");
    bit_in(1'b1, 1'b0, "ov_b4");
    bit_in(1'b0, 1'b1, "ov_b5");
    check("ov_cnt", 32'(match_cnt), 32'd2);

    // len 8, 0xA5 MSB-first with idle gaps
    cfg(8'hA5, 4'd8, 1'b0);
    bit_in(1'b1, 1'b0, "a5_b7");
    idle("a5_idle0");
    bit_in(1'b0, 1'b0, "a5_b6");
    bit_in(1'b1, 1'b0, "a5_b5");
    idle("a5_idle1");
    idle("a5_idle2");
    bit_in(1'b0, 1'b0, "a5_b4");
    bit_in(1'b0, 1'b0, "a5_b3");
    bit_in(1'b1, 1'b0, "a5_b2");
    idle("a5_idle3");
    bit_in(1'b0, 1'b0, "a5_b1");
    idle("a5_idle4");
    bit_in(1'b1, 1'b1, "a5_b0");
    idle("a5_after");
    check("a5_cnt", 32'(match_cnt), 32'd1);

    // Illegal lengths rejected, old config survives
    cfg(8'h02, 4'd3, 1'b0);
    cfg(8'hFF, 4'd0, 1'b1);
    check("err_len0", 32'(cfg_err), 32'd1);
    check("err_len0_armed", 32'(armed), 32'd1);
    tick();
    check("err_pulse_end", 32'(cfg_err), 32'd0);
    cfg(8'hFF, 4'd9, 1'b1);
    check("err_len9", 32'(cfg_err), 32'd1);
    bit_in(1'b0, 1'b0, "keep_b1");
    check("err_len9_end", 32'(cfg_err), 32'd0);
    bit_in(1'b1, 1'b0, "keep_b2");
    bit_in(1'b0, 1'b1, "keep_b3");
    check("keep_cnt", 32'(match_cnt), 32'd1);

    // len 1, overlap, saturation at 3
    cfg(8'h01, 4'd1, 1'b1);
    bit_in(1'b1, 1'b1, "sat_1");
    check("sat_cnt1", 32'(match_cnt), 32'd1);
    bit_in(1'b1, 1'b1, "sat_2");
    check("sat_cnt2", 32'(match_cnt), 32'd2);
    bit_in(1'b1, 1'b1, "sat_3");
    check("sat_cnt3", 32'(match_cnt), 32'd3);
    bit_in(1'b1, 1'b1, "sat_4");
    bit_in(1'b1, 1'b1, "sat_5");
    bit_in(1'b1, 1'b1, "sat_6");
    check("sat_hold", 32'(match_cnt), 32'd3);
    bit_in(1'b0, 1'b0, "sat_zero");

    // Reconfig mid-stream with a concurrent sample that must be dropped
    cfg(8'h02, 4'd3, 1'b1);
    bit_in(1'b0, 1'b0, "mid_b1");
    bit_in(1'b1, 1'b0, "mid_b2");
    valid  = 1'b1;
    in_bit = 1'b0;
    cfg(8'h02, 4'd3, 1'b1);
    check("mid_drop", 32'(match), 32'd0);
    check("mid_cnt", 32'(match_cnt), 32'd0);
    bit_in(1'b0, 1'b0, "mid_b3");
    bit_in(1'b1, 1'b0, "mid_b4");
    bit_in(1'b0, 1'b1, "mid_b5");
    check("mid_cnt1", 32'(match_cnt), 32'd1);

    // Reset mid-pattern beats a completing sample
    bit_in(1'b1, 1'b0, "rst_b1");
    valid  = 1'b1;
    in_bit = 1'b0;
    rst    = 1'b1;
    tick();
    check("mrst_match", 32'(match), 32'd0);
    check("mrst_armed", 32'(armed), 32'd0);
    check("mrst_cnt", 32'(match_cnt), 32'd0);
    check("mrst_err", 32'(cfg_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
